// File: rtl/rv523_arb_pkg.sv
// Shared types and defaults for the rv523 round-robin arbiter family.
package rv523_arb_pkg;

    localparam int unsigned ARB_DEF_N_REQ          = 4;
    localparam int unsigned ARB_DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_OWN     = 2'b01,
        ST_RELEASE = 2'b10
    } arb_state_e;

endpackage

// File: rtl/rv523_rr_pick.sv
// Rotating-priority picker: first set request scanning upward from ptr, wrapping.
module rv523_rr_pick import rv523_arb_pkg::*; #(
    parameter int unsigned N_REQ = ARB_DEF_N_REQ,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [ID_W-1:0]  win_id,
    output logic             any
);

    always_comb begin
        int unsigned sum;
        logic [ID_W-1:0] idx;
        win_oh = '0;
        win_id = '0;
        any    = 1'b0;
        sum    = 0;
        idx    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            // Modulo by subtraction keeps non-power-of-2 N_REQ in range.
            sum = 32'(ptr) + i;
            if (sum >= N_REQ) sum = sum - N_REQ;
            idx = ID_W'(sum);
            if (!any && req[idx]) begin
                any         = 1'b1;
                win_oh[idx] = 1'b1;
                win_id      = idx;
            end
        end
    end

endmodule

// File: rtl/rv523_rr_arbiter.sv
// Round-robin arbiter with grant hold until done and one dead cycle between owners.
// Optional ownership timeout enabled by defining RV523_ARB_TIMEOUT_EN.
module rv523_rr_arbiter import rv523_arb_pkg::*; #(
    parameter int unsigned N_REQ          = ARB_DEF_N_REQ,
    parameter int unsigned ID_W           = 2,
    parameter int unsigned TIMEOUT_CYCLES = ARB_DEF_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
`ifdef RV523_ARB_TIMEOUT_EN
    output logic             timeout,
`endif
    output logic             busy
);

    if (ID_W != $clog2(N_REQ) || CNT_W < $clog2(TIMEOUT_CYCLES)) begin : g_bad_cfg
        $error("rv523_rr_arbiter: ID_W/CNT_W inconsistent with N_REQ/TIMEOUT_CYCLES");
    end

    arb_state_e       state, state_n;
    logic [ID_W-1:0]  ptr, ptr_n;
    logic [N_REQ-1:0] gnt_n;
    logic [ID_W-1:0]  gnt_id_n;
    logic             busy_n;
    logic [N_REQ-1:0] win_oh;
    logic [ID_W-1:0]  win_id;
    logic             any;
    logic             release_c;
`ifdef RV523_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             timeout_n;
`endif

    rv523_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .win_oh (win_oh),
        .win_id (win_id),
        .any    (any)
    );

    // Ownership ends on done, or on counter expiry when the timeout is built in.
`ifdef RV523_ARB_TIMEOUT_EN
    assign release_c = done || (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign release_c = done;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
`ifdef RV523_ARB_TIMEOUT_EN
            cnt     <= '0;
            timeout <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            gnt     <= gnt_n;
            gnt_id  <= gnt_id_n;
            busy    <= busy_n;
`ifdef RV523_ARB_TIMEOUT_EN
            cnt     <= cnt_n;
            timeout <= timeout_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        gnt_n    = gnt;
        gnt_id_n = gnt_id;
        busy_n   = busy;
`ifdef RV523_ARB_TIMEOUT_EN
        cnt_n     = cnt;
        timeout_n = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (any) begin
                    state_n  = ST_OWN;
                    gnt_n    = win_oh;
                    gnt_id_n = win_id;
                    busy_n   = 1'b1;
`ifdef RV523_ARB_TIMEOUT_EN
                    cnt_n    = '0;
`endif
                end
            end
            ST_OWN: begin
`ifdef RV523_ARB_TIMEOUT_EN
                cnt_n = cnt + CNT_W'(1);
`endif
                if (release_c) begin
                    state_n  = ST_RELEASE;
                    gnt_n    = '0;
                    gnt_id_n = '0;
                    busy_n   = 1'b0;
                    ptr_n    = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
`ifdef RV523_ARB_TIMEOUT_EN
                    timeout_n = !done;
`endif
                end
            end
            ST_RELEASE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n  = ST_IDLE;
                gnt_n    = '0;
                gnt_id_n = '0;
                busy_n   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rv523_rr_arbiter.sv
// Directed bench for rv523_rr_arbiter (4 requesters); timeout scenario when RV523_ARB_TIMEOUT_EN is defined.
module tb_rv523_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
`ifdef RV523_ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int checks;
    int errors;

    rv523_rr_arbiter #(
        .N_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(8), .CNT_W(7)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .gnt_id (gnt_id),
`ifdef RV523_ARB_TIMEOUT_EN
        .timeout(timeout),
`endif
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: gnt=%b busy=%b id=%0d, want 0000/0/0", i, gnt, busy, gnt_id);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%b id=%0d busy=%b, want 0001/0/1", gnt, gnt_id, busy);
        end
        done = 1'b1; tick(); done = 1'b0; tick();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            tick();
            checks++;
            if (gnt !== exp_g || gnt_id !== 2'(k % 4) || busy !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant%0d: gnt=%b id=%0d busy=%b, want %b/%0d/1", k, gnt, gnt_id, busy, exp_g, k % 4);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
                errors++;
                $display("FAIL rr_release%0d: gnt=%b busy=%b id=%0d, want 0000/0/0", k, gnt, busy, gnt_id);
            end
            tick();
            checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_dead%0d: gnt=%b busy=%b, want 0000/0", k, gnt, busy);
            end
        end
        // ptr is now 1
    endtask

    task automatic test_skip_wrap();
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL skip_grant2: gnt=%b id=%0d, want 0100/2", gnt, gnt_id);
        end
        done = 1'b1; tick(); done = 1'b0; tick();
        req = 4'b0101;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL wrap_grant0: gnt=%b id=%0d, want 0001/0", gnt, gnt_id);
        end
        done = 1'b1; tick(); done = 1'b0; tick();
        tick();
        checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL wrap_next2: gnt=%b id=%0d, want 0100/2", gnt, gnt_id);
        end
        done = 1'b1; tick(); done = 1'b0; req = 4'b0000; tick();
        // ptr is now 3
    endtask

    task automatic test_hold();
        int n;
`ifdef RV523_ARB_TIMEOUT_EN
        n = 6;
`else
        n = 70;
`endif
        req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL hold_grant1: gnt=%b id=%0d, want 0010/1", gnt, gnt_id);
        end
        req = 4'b0000;
        for (int i = 0; i < n; i++) begin
            if (i == 3) req = 4'b1101;
            tick();
            checks++;
            if (gnt !== 4'b0010 || gnt_id !== 2'd1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_cyc%0d: gnt=%b id=%0d busy=%b, want 0010/1/1", i, gnt, gnt_id, busy);
            end
        end
        req = 4'b0000;
        done = 1'b1; tick(); done = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_done_release: gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
        tick();
        // ptr is now 2
    endtask

    task automatic test_spurious_done();
        req = 4'b0000; done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_done%0d: gnt=%b busy=%b, want 0000/0", i, gnt, busy);
            end
        end
        done = 1'b0;
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL spurious_ptr_kept: gnt=%b id=%0d, want 0100/2", gnt, gnt_id);
        end
    endtask

    task automatic test_reset_mid_own();
        // Owner 2 still holds from the previous task.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: gnt=%b busy=%b id=%0d, want 0000/0/0", gnt, busy, gnt_id);
        end
        tick();
        rst = 1'b0;
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_ptr_cleared: gnt=%b id=%0d, want 0001/0", gnt, gnt_id);
        end
        done = 1'b1; tick(); done = 1'b0; req = 4'b0000; tick();
        // ptr is now 1
    endtask

`ifdef RV523_ARB_TIMEOUT_EN
    task automatic test_timeout();
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_grant2: gnt=%b timeout=%b, want 0100/0", gnt, timeout);
        end
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0100 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold%0d: gnt=%b timeout=%b, want 0100/0", i, gnt, timeout);
            end
        end
        tick();
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_expire: gnt=%b busy=%b timeout=%b, want 0000/0/1", gnt, busy, timeout);
        end
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse_end: gnt=%b timeout=%b, want 0000/0", gnt, timeout);
        end
        tick();
        checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
            errors++;
            $display("FAIL to_next3: gnt=%b id=%0d, want 1000/3", gnt, gnt_id);
        end
        // DONE on the expiry edge counts as a normal release.
        for (int i = 0; i < 7; i++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (gnt !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_done_wins: gnt=%b timeout=%b, want 0000/0", gnt, timeout);
        end
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL to_done_ptr: gnt=%b, want 0001", gnt);
        end
        done = 1'b1; tick(); done = 1'b0; req = 4'b0000; tick();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        test_reset();
        test_round_robin();
        test_skip_wrap();
        test_hold();
        test_spurious_done();
        test_reset_mid_own();
`ifdef RV523_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
